// File: rtl/cop_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : cop_pkg                                                      |
// | Description : Shared opcodes, FSM encoding and response record for cop_arb |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package cop_pkg;

  localparam logic [6:0] CUSTOM_0 = 7'h0B;
  localparam logic [6:0] CUSTOM_1 = 7'h2B;
  localparam logic [6:0] CUSTOM_2 = 7'h5B;
  localparam logic [6:0] CUSTOM_3 = 7'h7B;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } cop_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        id;
  } cop_rsp_t;

endpackage

`default_nettype wire

// File: rtl/cop_rr_arb.sv
// +----------------------------------------------------------------------------+
// | Module      : cop_rr_arb                                                   |
// | Description : 2-way round-robin / fixed-priority picker, one-hot grant     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module cop_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_fix,
  output logic [1:0] grant
);

  // A lone requester always wins; a tie goes to 0 under fixed priority or
  // when requester 1 was the previous winner.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (prio_fix || last) ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cop_arb.sv
// +----------------------------------------------------------------------------+
// | Module      : cop_arb                                                      |
// | Description : Two-requester front end sharing one coprocessor port.        |
// |               Optional completion timeout: define COP_ARB_TIMEOUT_EN.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module cop_arb
  import cop_pkg::*;
#(
  parameter logic        PRIO_FIX = 1'b0,
  parameter int unsigned TMO_CYC  = 16
) (
  input  logic        cop_clk,
  input  logic        cop_rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_insn,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        cop_valid,
  output logic        cop_rdywr,
  output logic [31:0] cop_insn,
  output logic [31:0] cop_rs1,
  output logic [31:0] cop_rs2,
  input  logic        cop_ready,
  input  logic        cop_wait,
  input  logic        cop_wr,
  input  logic [31:0] cop_rd
);

  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("TMO_CYC must be at least 1");
  end

  cop_state_e  r_state;
  cop_state_e  w_state_nxt;
  cop_rsp_t    r_rsp;
  logic        r_rsp_full;
  logic        r_last;
  logic        r_owner;
  logic [31:0] r_insn;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;

  logic [1:0]  w_grant;
  logic        w_gnt_idx;
  logic        w_grant_en;
  logic        w_take;
  logic        w_issue;
  logic        w_pop;
  logic        w_rsp_free;
  logic        w_done_good;
  logic        w_done_unsup;
  logic        w_done_tmo;
  logic        w_done;

  cop_rr_arb u_rr (
    .req      (req_valid),
    .last     (r_last),
    .prio_fix (PRIO_FIX),
    .grant    (w_grant)
  );

  assign w_issue      = (r_state == ST_ISSUE);
  assign w_pop        = r_rsp_full & rsp_ready[r_rsp.id];
  assign w_rsp_free   = !r_rsp_full | w_pop;
  assign w_done_good  = w_issue & !cop_wait & cop_wr & cop_ready & w_rsp_free;
  assign w_done_unsup = w_issue & !cop_wait & !cop_wr & w_rsp_free;
  assign w_done       = w_done_good | w_done_unsup | w_done_tmo;

  // No acceptance while reset is held: the instruction would be discarded.
  assign w_grant_en = !cop_rst & ((!w_issue & w_rsp_free) | w_done);
  assign w_take     = w_grant_en & (|req_valid);
  assign w_gnt_idx  = w_grant[1];
  assign req_ready  = w_grant_en ? w_grant : 2'b00;

`ifdef COP_ARB_TIMEOUT_EN
  localparam int unsigned c_tmo_w = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [c_tmo_w-1:0] r_tmo_cnt;

  // Only cycles where the response slot could accept a result count as stuck.
  assign w_done_tmo = w_issue & w_rsp_free & !(w_done_good | w_done_unsup) &
                      (r_tmo_cnt == c_tmo_w'(TMO_CYC - 1));

  always_ff @(posedge cop_clk) begin
    if (cop_rst || w_done || w_take) begin
      r_tmo_cnt <= '0;
    end else if (w_issue && w_rsp_free) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_done_tmo = 1'b0;
`endif

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_take) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_done) w_state_nxt = w_take ? ST_ISSUE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      r_insn  <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_take) begin
      r_insn  <= w_gnt_idx ? req_insn[63:32] : req_insn[31:0];
      r_rs1   <= w_gnt_idx ? req_rs1[63:32]  : req_rs1[31:0];
      r_rs2   <= w_gnt_idx ? req_rs2[63:32]  : req_rs2[31:0];
      r_owner <= w_gnt_idx;
      r_last  <= w_gnt_idx;
    end
  end

  // A load in the same cycle as a pop wins, so back-to-back results never gap.
  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      r_rsp_full <= 1'b0;
      r_rsp      <= '0;
    end else if (w_done) begin
      r_rsp_full <= 1'b1;
      r_rsp.data <= w_done_good ? cop_rd : 32'h0;
      r_rsp.err  <= !w_done_good;
      r_rsp.id   <= r_owner;
    end else if (w_pop) begin
      r_rsp_full <= 1'b0;
    end
  end

  assign cop_valid = w_issue;
  assign cop_rdywr = w_rsp_free;
  assign cop_insn  = w_issue ? r_insn : 32'h0;
  assign cop_rs1   = w_issue ? r_rs1  : 32'h0;
  assign cop_rs2   = w_issue ? r_rs2  : 32'h0;

  assign rsp_valid = {r_rsp_full & r_rsp.id, r_rsp_full & !r_rsp.id};
  assign rsp_data  = r_rsp.data;
  assign rsp_err   = r_rsp.err;

endmodule

`default_nettype wire

// File: tb/tb_cop_arb.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_cop_arb                                                   |
// | Description : Directed self-checking bench for cop_arb with a cop stub     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cop_arb;
  import cop_pkg::*;

  logic        cop_clk = 1'b0;
  logic        cop_rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [63:0] req_insn = '0;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2 = '0;
  logic [1:0]  rsp_ready = 2'b00;
  logic        stub_wait = 1'b0;
  logic        stub_ready = 1'b1;

  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data, cop_insn, cop_rs1, cop_rs2, cop_rd;
  logic        rsp_err, cop_valid, cop_rdywr, cop_ready, cop_wait, cop_wr;

  logic [1:0]  f_req_ready, f_rsp_valid;
  logic [31:0] f_rsp_data, f_cop_insn, f_cop_rs1, f_cop_rs2, f_cop_rd;
  logic        f_rsp_err, f_cop_valid, f_cop_rdywr, f_cop_wr;

  int n_vec = 0;
  int n_err = 0;

  always #5 cop_clk = ~cop_clk;

  // Behavioural coprocessor stubs: xor of operands, only CUSTOM_2 writes back.
  assign cop_rd    = cop_rs1 ^ cop_rs2;
  assign cop_wr    = cop_valid & (cop_insn[6:0] == CUSTOM_2);
  assign cop_ready = stub_ready;
  assign cop_wait  = stub_wait;
  assign f_cop_rd  = f_cop_rs1 ^ f_cop_rs2;
  assign f_cop_wr  = f_cop_valid & (f_cop_insn[6:0] == CUSTOM_2);

  cop_arb #(.PRIO_FIX(1'b0), .TMO_CYC(16)) dut (
    .cop_clk(cop_clk), .cop_rst(cop_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cop_valid(cop_valid), .cop_rdywr(cop_rdywr), .cop_insn(cop_insn),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
    .cop_ready(cop_ready), .cop_wait(cop_wait), .cop_wr(cop_wr), .cop_rd(cop_rd)
  );

  cop_arb #(.PRIO_FIX(1'b1), .TMO_CYC(16)) dut_fix (
    .cop_clk(cop_clk), .cop_rst(cop_rst),
    .req_valid(req_valid), .req_ready(f_req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(f_rsp_valid), .rsp_ready(2'b11),
    .rsp_data(f_rsp_data), .rsp_err(f_rsp_err),
    .cop_valid(f_cop_valid), .cop_rdywr(f_cop_rdywr), .cop_insn(f_cop_insn),
    .cop_rs1(f_cop_rs1), .cop_rs2(f_cop_rs2),
    .cop_ready(1'b1), .cop_wait(1'b0), .cop_wr(f_cop_wr), .cop_rd(f_cop_rd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cop_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge cop_clk);
  endtask

  // Transaction-level model: every acceptance predicts one response, responses
  // leave in acceptance order, ties alternate, and the port shows the last accept.
  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic        m_last = 1'b1;
  logic        m_tmo = 1'b0;
  logic [31:0] m_insn = '0;
  logic [31:0] m_rs1 = '0;

  always @(negedge cop_clk) begin : p_cmp
    exp_t        e;
    logic        g;
    logic [31:0] ins;
    if (cop_rst) begin
      sb.delete();
      m_last = 1'b1;
    end else begin
      check("rdywr", cop_rdywr, (rsp_valid == 2'b00) || ((rsp_valid & rsp_ready) != 2'b00));
      if (cop_valid) begin
        check("cop_insn", cop_insn, m_insn);
        check("cop_rs1", cop_rs1, m_rs1);
      end else begin
        check("idle_insn", cop_insn, 32'h0);
      end
      check("rsp_onehot", (rsp_valid == 2'b11), 1'b0);
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        check("rsp_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_id", rsp_valid, e.id ? 2'b10 : 2'b01);
          check("rsp_data", rsp_data, e.data);
          check("rsp_err", rsp_err, e.err);
        end
      end
      if (req_ready != 2'b00) begin
        g = req_ready[1];
        check("grant_onehot", $countones(req_ready), 1);
        check("grant_valid", req_valid[g], 1'b1);
        if (req_valid == 2'b11) check("rr_alt", g, !m_last);
        ins    = req_insn[g*32 +: 32];
        e.id   = g;
        e.err  = m_tmo || (ins[6:0] != CUSTOM_2);
        e.data = e.err ? 32'h0 : (req_rs1[g*32 +: 32] ^ req_rs2[g*32 +: 32]);
        sb.push_back(e);
        m_insn = ins;
        m_rs1  = req_rs1[g*32 +: 32];
        m_last = g;
      end
    end
  end

  initial begin
    repeat (3) @(posedge cop_clk);
    #1 cop_rst = 1'b0;
    smp();
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_cop_valid", cop_valid, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    tick();

    // Single supported request, minimum latency
    req_insn = {32'h0, 32'h0000005B};
    req_rs1  = {32'h0, 32'hF0F0F0F0};
    req_rs2  = {32'h0, 32'h0F0F0F0F};
    req_valid = 2'b01;
    smp(); check("t1_ready_c0", req_ready, 2'b01); tick();
    req_valid = 2'b00;
    smp();
    check("t1_cop_valid_c1", cop_valid, 1'b1);
    check("t1_cop_insn_c1", cop_insn, 32'h0000005B);
    check("t1_rsp_c1", rsp_valid, 2'b00);
    tick();
    smp();
    check("t1_rsp_valid_c2", rsp_valid, 2'b01);
    check("t1_rsp_data", rsp_data, 32'hFFFFFFFF);
    check("t1_rsp_err", rsp_err, 1'b0);
    tick();
    rsp_ready = 2'b01;
    smp(); check("t1_held", rsp_valid, 2'b01); tick();
    smp(); check("t1_drained", rsp_valid, 2'b00); tick();

    // Unsupported instruction from requester 1
    req_insn = {32'h0000007F, 32'h0};
    req_rs1  = {32'h12345678, 32'h0};
    req_rs2  = {32'h9ABCDEF0, 32'h0};
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    smp(); check("t2_ready", req_ready, 2'b10); tick();
    req_valid = 2'b00;
    smp(); check("t2_cop_insn", cop_insn, 32'h0000007F); tick();
    smp();
    check("t2_rsp_valid", rsp_valid, 2'b10);
    check("t2_rsp_data", rsp_data, 32'h0);
    check("t2_rsp_err", rsp_err, 1'b1);
    tick();
    smp(); check("t2_drained", rsp_valid, 2'b00); tick();

    // Both requesters continuously valid: alternate, fixed-priority copy stays on 0
    req_insn = {32'h0000005B, 32'h0000005B};
    req_rs1  = {32'h00000011, 32'h00000022};
    req_rs2  = {32'h00000100, 32'h00000200};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      smp();
      check("rr_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      check("fix_grant", f_req_ready, 2'b01);
      tick();
    end
    req_valid = 2'b00;
    repeat (3) begin smp(); tick(); end
    smp(); check("rr_drained", rsp_valid, 2'b00); tick();

    // Backpressure with a second request behind the first
    req_insn = {32'h0000005B, 32'h0000005B};
    req_rs1  = {32'h00000010, 32'h00000001};
    req_rs2  = {32'h00000020, 32'h00000002};
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    smp(); check("bp_acc0", req_ready, 2'b01); tick();
    req_valid = 2'b10;
    smp(); check("bp_acc1", req_ready, 2'b10); tick();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      smp();
      check("bp_rdywr", cop_rdywr, 1'b0);
      check("bp_hold_valid", cop_valid, 1'b1);
      check("bp_rsp0", rsp_valid, 2'b01);
      check("bp_rsp0_data", rsp_data, 32'h00000003);
      tick();
    end
    rsp_ready = 2'b11;
    smp(); check("bp_release", cop_rdywr, 1'b1); tick();
    smp();
    check("bp_rsp1", rsp_valid, 2'b10);
    check("bp_rsp1_data", rsp_data, 32'h00000030);
    tick();
    smp(); check("bp_drained", rsp_valid, 2'b00); tick();

    // Coprocessor wait stall
    req_insn  = {32'h0, 32'h0000005B};
    req_rs1   = {32'h0, 32'h00000005};
    req_rs2   = {32'h0, 32'h00000003};
    stub_wait = 1'b1;
    req_valid = 2'b01;
    smp(); check("w_acc", req_ready, 2'b01); tick();
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("w_hold", cop_valid, 1'b1);
      check("w_no_rsp", rsp_valid, 2'b00);
      tick();
    end
    stub_wait = 1'b0;
    smp(); tick();
    smp(); check("w_rsp", rsp_valid, 2'b01); check("w_data", rsp_data, 32'h00000006); tick();

`ifdef COP_ARB_TIMEOUT_EN
    // Completion timeout while the coprocessor never stops waiting
    m_tmo     = 1'b1;
    stub_wait = 1'b1;
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    smp(); check("tmo_acc", req_ready, 2'b01); tick();
    req_valid = 2'b00;
    for (int k = 1; k <= 16; k++) begin
      smp(); check("tmo_hold", rsp_valid, 2'b00); tick();
    end
    smp();
    check("tmo_rsp", rsp_valid, 2'b01);
    check("tmo_err", rsp_err, 1'b1);
    check("tmo_data", rsp_data, 32'h0);
    tick();
    m_tmo     = 1'b0;
    stub_wait = 1'b0;
    rsp_ready = 2'b11;
    smp(); tick();
`endif

    // Reset in the middle of an issue
    stub_wait = 1'b1;
    req_insn  = {32'h0000005B, 32'h0000005B};
    req_valid = 2'b01;
    smp(); check("r_acc", req_ready, 2'b01); tick();
    cop_rst   = 1'b1;
    req_valid = 2'b00;
    smp(); check("r_inflight", cop_valid, 1'b1); tick();
    cop_rst   = 1'b0;
    stub_wait = 1'b0;
    smp();
    check("r_cop_valid", cop_valid, 1'b0);
    check("r_rsp_valid", rsp_valid, 2'b00);
    check("r_req_ready", req_ready, 2'b00);
    tick();
    req_valid = 2'b11;
    smp(); check("r_first_grant", req_ready, 2'b01); tick();
    req_valid = 2'b00;
    repeat (3) begin smp(); tick(); end
    smp(); check("r_drained", rsp_valid, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/cop_arb.md
COP_ARB -- requirements
Module: cop_arb

Interface
REQ-001 SHALL have parameter PRIO_FIX, default 1'b0, meaning 0 = round-robin between requesters and 1 = fixed priority to requester 0.
REQ-002 SHALL have parameter TMO_CYC, default 16, meaning the completion-timeout limit in cycles (used only under COP_ARB_TIMEOUT_EN).
REQ-003 SHALL have port cop_clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port cop_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 2 bits: per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready, output, 2 bits: per-requester one-cycle accept pulse.
REQ-007 SHALL have port req_insn, input, 64 bits: instruction words, requester i in bits [32i+31:32i].
REQ-008 SHALL have ports req_rs1 and req_rs2, input, 64 bits each: operands, packed as req_insn.
REQ-009 SHALL have port rsp_valid, output, 2 bits: response valid, routed to the owning requester.
REQ-010 SHALL have port rsp_ready, input, 2 bits: response accept.
REQ-011 SHALL have port rsp_data, output, 32 bits: response result, shared by both requesters.
REQ-012 SHALL have port rsp_err, output, 1 bit: 1 = instruction unsupported or timed out.
REQ-013 SHALL have ports cop_valid, cop_rdywr, cop_insn, cop_rs1 and cop_rs2 as outputs (1, 1, 32, 32, 32 bits), driving the coprocessor.
REQ-014 SHALL have ports cop_ready, cop_wait, cop_wr and cop_rd as inputs (1, 1, 1, 32 bits), from the coprocessor.

Function
REQ-015 SHALL implement the FSM states IDLE and ISSUE.
REQ-016 SHALL capture insn/rs1/rs2 of the granted requester into the issue register, pulse req_ready[grant] for one cycle and enter ISSUE.
REQ-017 SHALL, in ISSUE, drive cop_valid=1 with the issue register contents held stable until completion.
REQ-018 SHALL define rsp_free = !rsp_full | (rsp_ready[rsp_id] & rsp_full) and drive cop_rdywr = rsp_free.
REQ-019 SHALL treat cop_valid & !cop_wait & cop_wr & cop_ready & rsp_free as a good completion: load rsp_data=cop_rd, rsp_err=0, rsp_id=owner, rsp_full=1.
REQ-020 SHALL treat cop_valid & !cop_wait & !cop_wr & rsp_free as an unsupported completion: load rsp_data=0, rsp_err=1.
REQ-021 SHALL hold in ISSUE while cop_wait=1, or while cop_wr=1 and cop_ready=0, or while rsp_free=0.
REQ-022 SHALL, on completion with any req_valid set, grant the next requester in the same cycle and remain in ISSUE (one instruction per cycle sustained); otherwise it SHALL return to IDLE.
REQ-023 SHALL grant only when rsp_free, or when a completion occurs in that cycle.
REQ-024 SHALL, when PRIO_FIX=0 and both requesters are valid, grant the requester not granted last; when only one is valid it SHALL grant that one.
REQ-025 SHALL, when PRIO_FIX=1, always grant requester 0 over requester 1.
REQ-026 SHALL have a minimum latency of: request accepted in cycle 0, cop_valid in cycle 1, rsp_valid in cycle 2.
REQ-027 SHALL drive rsp_valid[i] = rsp_full & (rsp_id==i), and SHALL clear rsp_full on pop unless reloaded in the same cycle.
REQ-028 SHALL give a simultaneous pop and completion priority to the load, leaving rsp_full=1 with the new data.
REQ-029 SHALL drive cop_insn, cop_rs1 and cop_rs2 to 0 in IDLE.

Reset
REQ-030 SHALL, on cop_rst=1 at a clock edge, set state=IDLE, rsp_full=0, rsp_data=0, rsp_err=0, rsp_id=0 and last-grant=1 (requester 0 wins first).
REQ-031 SHALL, with these reset values, drive cop_valid=0, req_ready=0 and rsp_valid=0.
REQ-032 SHALL, on reset mid-operation, discard the in-flight instruction and any pending response with no response produced.
REQ-033 SHALL drive all outputs to their reset values in the cycle after cop_rst is sampled high.

Configuration
REQ-034 SHALL, with macro COP_ARB_TIMEOUT_EN defined, count consecutive non-completing ISSUE cycles in which rsp_free=1.
REQ-035 SHALL, when that count reaches TMO_CYC under COP_ARB_TIMEOUT_EN, force a completion with rsp_data=0 and rsp_err=1, and SHALL reset the counter on every completion or grant.
REQ-036 SHALL, without COP_ARB_TIMEOUT_EN, contain no counter, and ISSUE SHALL wait indefinitely.

Structure
REQ-037 SHALL take from shared package cop_pkg: CUSTOM_0..CUSTOM_3 opcode constants, the FSM state encoding and the response-record type (data, err, id).
REQ-038 SHALL place the 2-way round-robin/fixed-priority picker in sub-module cop_rr_arb (inputs: req, last, prio_fix; output: one-hot grant).
REQ-039 SHALL instantiate no coprocessor; cop_ise is connected externally.

Verification (behavioural cop stub: cop_rd = rs1^rs2, cop_wr = valid & (opcode==CUSTOM_2))
REQ-040 SHALL verify single request: req0 insn=0x0000005B, rs1=0xF0F0F0F0, rs2=0x0F0F0F0F -> req_ready[0] in cycle 0, rsp_valid[0] in cycle 2, rsp_data=0xFFFFFFFF, rsp_err=0.
REQ-041 SHALL verify unsupported instruction: req1 insn=0x0000007F -> rsp_valid[1], rsp_data=0, rsp_err=1.
REQ-042 SHALL verify round-robin: both requesters valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; with PRIO_FIX=1 all grants go to 0.
REQ-043 SHALL verify backpressure: rsp_ready=0 for 5 cycles with a second request pending -> cop_rdywr=0, no data lost, responses delivered in order after release.
REQ-044 SHALL verify timeout: under COP_ARB_TIMEOUT_EN with TMO_CYC=16, stub holds cop_wait=1 -> rsp_err=1 after 16 ISSUE cycles.
REQ-045 SHALL verify reset mid-operation: cop_rst=1 while in ISSUE -> next cycle cop_valid=0 and rsp_valid=00, and the first grant after reset goes to req0.
